contador_param: RTL and testbench
=================================

CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 15: terminal value (modulus minus 1); legal range 1..2^WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable.
REQ-007 updown  input  1  direction: 1 = up, 0 = down.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 clr_ovf  input  1  clears the sticky overflow flag.
REQ-011 out  output  WIDTH  current count (registered).
REQ-012 tc  output  1  terminal-count pulse (registered).
REQ-013 ovf  output  1  sticky boundary-crossing flag (registered).

Function
REQ-014 Priority per rising edge SHALL be reset > load > en > hold.
REQ-015 Reset SHALL set out to 0 when updown=1 and to MAX_VAL when updown=0, as sampled on the same edge.
REQ-016 Load SHALL set out to load_val, clamped to MAX_VAL when load_val > MAX_VAL; load SHALL NOT assert tc or set ovf.
REQ-017 With en=1 and updown=1 and out<MAX_VAL, out SHALL increment by 1 on the next edge.
REQ-018 With en=1 and updown=0 and out>0, out SHALL decrement by 1 on the next edge.
REQ-019 Up at out=MAX_VAL with en=1: next out SHALL be 0 (SATURATE=0) or MAX_VAL (SATURATE=1).
REQ-020 Down at out=0 with en=1: next out SHALL be MAX_VAL (SATURATE=0) or 0 (SATURATE=1).
REQ-021 A boundary event is an REQ-019 or REQ-020 step; tc SHALL be 1 for exactly the cycle following the edge at which the event occurred, otherwise 0.
REQ-022 On consecutive boundary events (SATURATE=1 holding with en=1), tc SHALL remain 1 on each such cycle.
REQ-023 A boundary event SHALL set ovf to 1 on the same edge; ovf SHALL stay 1 until clr_ovf=1 or reset.
REQ-024 If clr_ovf=1 coincides with a boundary event, ovf SHALL be 1 (set wins).
REQ-025 With en=0 and load=0, out SHALL hold and tc SHALL be 0.
REQ-026 Direction changes SHALL take effect on the edge where updown is sampled, with no extra latency.
REQ-027 All internal arithmetic SHALL be WIDTH bits wide; out SHALL never exceed MAX_VAL.
REQ-028 Outputs SHALL be functions of registered state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-029 Reset SHALL force tc=0 and ovf=0 on the same edge, and set out per REQ-015.
REQ-030 Reset asserted mid-count SHALL override load, en and clr_ovf on that edge.
REQ-031 After reset deasserts, counting SHALL resume on the first edge with en=1.
REQ-032 Out, tc and ovf are undefined before the first reset edge; the bench SHALL apply reset before checking.

Verification (WIDTH=4, MAX_VAL=9 unless noted)
REQ-033 Reset with updown=1 -> out=0, tc=0, ovf=0; reset with updown=0 -> out=9.
REQ-034 SATURATE=0, up, en=1 for 11 cycles from 0 -> out 1..9,0,1; tc=1 only in the cycle out=0; ovf=1 thereafter.
REQ-035 SATURATE=1, down from 2, en=1 for 4 cycles -> out 1,0,0,0; tc=1 on the last two cycles; ovf=1.
REQ-036 load=1, load_val=13 with en=1 -> out=9, tc=0, ovf unchanged; load_val=5 -> out=5.
REQ-037 ovf=1, then clr_ovf=1 coincident with an up-wrap 9->0 -> ovf stays 1; next cycle clr_ovf=1 alone -> ovf=0.
REQ-038 Reset asserted at out=6 with load=1, load_val=3 and updown=0 -> out=9, tc=0, ovf=0.

Source files
------------

// File: rtl/contador_param.sv
// Parameterised up/down modulo counter with optional saturation, synchronous load,
// registered terminal-count pulse and a sticky boundary-crossing flag.
module contador_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 15,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic             at_top, at_bot, boundary;
  logic [WIDTH-1:0] step_val, load_clamped;

  assign at_top       = (out_q == MaxVal);
  assign at_bot       = (out_q == '0);
  assign boundary     = updown ? at_top : at_bot;
  assign load_clamped = (load_val > MaxVal) ? MaxVal : load_val;

  always_comb begin
    step_val = out_q;
    if (updown) begin
      if (at_top) step_val = SATURATE ? MaxVal : '0;
      else        step_val = out_q + One;
    end else begin
      if (at_bot) step_val = SATURATE ? '0 : MaxVal;
      else        step_val = out_q - One;
    end
  end

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~clr_ovf;
    if (load) begin
      out_d = load_clamped;
    end else if (en) begin
      out_d = step_val;
      tc_d  = boundary;
      // A boundary event wins over a simultaneous clear.
      ovf_d = boundary | (ovf_q & ~clr_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= updown ? '0 : MaxVal;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: wrapping and saturating instances (WIDTH=4, MAX_VAL=9) driven
// in lockstep, checked against an arithmetic reference model and directed expectations.
module tb_contador_param;

  localparam int MaxV = 9;

  logic       clk;
  logic       reset, en, updown, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] out_w, out_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int tests;
  int fails;

  int m_out [2];
  bit m_tc  [2];
  bit m_ovf [2];
  bit m_valid;

  contador_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .out(out_w), .tc(tc_w), .ovf(ovf_w)
  );

  contador_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .out(out_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: count in plain integers; a step leaving [0, MaxV] is a boundary event,
  // resolved by modular arithmetic (wrap) or by refusing the step (saturate).
  task automatic model_update(input bit r, input bit l, input int lv, input bit e,
                              input bit ud, input bit c);
    for (int s = 0; s < 2; s++) begin
      if (r) begin
        m_out[s] = ud ? 0 : MaxV;
        m_tc[s]  = 1'b0;
        m_ovf[s] = 1'b0;
      end else if (l) begin
        m_out[s] = (lv > MaxV) ? MaxV : lv;
        m_tc[s]  = 1'b0;
        if (c) m_ovf[s] = 1'b0;
      end else if (e) begin
        int nxt;
        bit bnd;
        nxt = m_out[s] + (ud ? 1 : -1);
        bnd = (nxt < 0) || (nxt > MaxV);
        if (!bnd)      m_out[s] = nxt;
        else if (s == 0) m_out[s] = (nxt + MaxV + 1) % (MaxV + 1);
        m_tc[s] = bnd;
        if (c)   m_ovf[s] = 1'b0;
        if (bnd) m_ovf[s] = 1'b1;
      end else begin
        m_tc[s] = 1'b0;
        if (c) m_ovf[s] = 1'b0;
      end
    end
    if (r) m_valid = 1'b1;
  endtask

  task automatic check_model();
    if (m_valid) begin
      chk("wrap_out", 32'(out_w), 32'(m_out[0]));
      chk("wrap_tc",  32'(tc_w),  32'(m_tc[0]));
      chk("wrap_ovf", 32'(ovf_w), 32'(m_ovf[0]));
      chk("sat_out",  32'(out_s), 32'(m_out[1]));
      chk("sat_tc",   32'(tc_s),  32'(m_tc[1]));
      chk("sat_ovf",  32'(ovf_s), 32'(m_ovf[1]));
    end
  endtask

  task automatic cycle(input bit r, input bit l, input int lv, input bit e, input bit ud,
                       input bit c);
    reset    = r;
    load     = l;
    load_val = 4'(lv);
    en       = e;
    updown   = ud;
    clr_ovf  = c;
    @(posedge clk);
    model_update(r, l, lv, e, ud, c);
    #1;
    check_model();
  endtask

  initial begin
    int exp34 [11];
    tests   = 0;
    fails   = 0;
    m_valid = 1'b0;
    exp34   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

    // Reset values for both directions
    cycle(1, 0, 0, 0, 1, 0);
    chk("rst_up_out", 32'(out_w), 0);
    chk("rst_up_tc",  32'(tc_w),  0);
    chk("rst_up_ovf", 32'(ovf_w), 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_dn_out", 32'(out_s), 9);

    // Wrapping up-count through the terminal value
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 11; i++) begin
      cycle(0, 0, 0, 1, 1, 0);
      chk("up_wrap_out", 32'(out_w), 32'(exp34[i]));
      chk("up_wrap_tc",  32'(tc_w),  (i == 9) ? 1 : 0);
      chk("up_wrap_ovf", 32'(ovf_w), (i >= 9) ? 1 : 0);
    end

    // Saturating down-count from 2
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      chk("dn_sat_out", 32'(out_s), (i == 0) ? 1 : 0);
      chk("dn_sat_tc",  32'(tc_s),  (i >= 2) ? 1 : 0);
      chk("dn_sat_ovf", 32'(ovf_s), (i >= 2) ? 1 : 0);
    end

    // Load clamps and does not disturb tc/ovf
    cycle(0, 1, 13, 1, 1, 0);
    chk("load13_out", 32'(out_s), 9);
    chk("load13_tc",  32'(tc_s),  0);
    chk("load13_ovf", 32'(ovf_s), 1);
    cycle(0, 1, 5, 1, 1, 0);
    chk("load5_out", 32'(out_w), 5);

    // Clear coincident with a wrap keeps ovf; clear alone drops it
    cycle(0, 1, 9, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 1);
    chk("clr_wrap_out", 32'(out_w), 0);
    chk("clr_wrap_ovf", 32'(ovf_w), 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("clr_only_ovf", 32'(ovf_w), 0);
    chk("hold_tc",      32'(tc_w),  0);

    // Reset overrides a simultaneous load mid-count
    cycle(0, 1, 6, 0, 1, 0);
    cycle(1, 1, 3, 1, 0, 1);
    chk("rst_ovr_out", 32'(out_w), 9);
    chk("rst_ovr_tc",  32'(tc_w),  0);
    chk("rst_ovr_ovf", 32'(ovf_w), 0);
    cycle(0, 0, 0, 1, 1, 0);
    chk("resume_out", 32'(out_w), 0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(31) == 0), ($urandom_range(7) == 0), int'($urandom_range(15)),
            ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
